// File: rtl/gpr_wport_arbiter_if.sv
// Signal bundle between the writeback/long-latency producers and the GPR write-port arbiter.
// The master side drives requests; the slave side is the arbiter.
interface gpr_wport_arbiter_if;
    logic        ws_valid;
    logic        ws_ready;
    logic [4:0]  ws_waddr;
    logic [31:0] ws_wdata;
    logic        ll_issue;
    logic [4:0]  ll_issue_dest;
    logic        ll_valid;
    logic        ll_ready;
    logic [4:0]  ll_waddr;
    logic [31:0] ll_wdata;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] busy_vec;

    modport master (
        output ws_valid, ws_waddr, ws_wdata,
        output ll_issue, ll_issue_dest,
        output ll_valid, ll_waddr, ll_wdata,
        input  ws_ready, ll_ready,
        input  rf_we, rf_waddr, rf_wdata, busy_vec
    );

    modport slave (
        input  ws_valid, ws_waddr, ws_wdata,
        input  ll_issue, ll_issue_dest,
        input  ll_valid, ll_waddr, ll_wdata,
        output ws_ready, ll_ready,
        output rf_we, rf_waddr, rf_wdata, busy_vec
    );
endinterface

// File: rtl/gpr_wport_arbiter.sv
// Arbitrates the GPR write port between writeback and buffered long-latency results,
// with starvation forcing and a busy scoreboard for pending long-latency destinations.
module gpr_wport_arbiter #(
    parameter int unsigned STARVE_LIMIT  = 4,
    parameter int unsigned LL_FIFO_DEPTH = 2
) (
    input  logic               clk,
    input  logic               resetn,
    gpr_wport_arbiter_if.slave bus
);
    localparam int unsigned AW       = (LL_FIFO_DEPTH > 1) ? $clog2(LL_FIFO_DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(LL_FIFO_DEPTH);
    localparam logic [2:0]  LIMIT    = 3'(STARVE_LIMIT);

    logic [4:0]    mem_addr_q [LL_FIFO_DEPTH];
    logic [31:0]   mem_data_q [LL_FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [2:0]    starve_q, starve_d;
    logic          rf_we_q, rf_we_d;
    logic [4:0]    rf_waddr_q, rf_waddr_d;
    logic [31:0]   rf_wdata_q, rf_wdata_d;
    logic [31:0]   busy_q, busy_d;

    logic          empty, full, enq;
    logic          force_ll, grant_wb, grant_ll;
    logic [4:0]    head_addr;
    logic [31:0]   head_data;

    always_comb begin
        empty     = (cnt_q == '0);
        full      = (cnt_q == FULL_CNT);
        enq       = bus.ll_valid && !full;
        head_addr = mem_addr_q[rd_ptr_q];
        head_data = mem_data_q[rd_ptr_q];
        force_ll  = !empty && (starve_q == LIMIT);
        grant_wb  = !force_ll && bus.ws_valid;
        grant_ll  = !grant_wb && !empty;
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q + AW'(enq);
        rd_ptr_d   = rd_ptr_q + AW'(grant_ll);
        cnt_d      = cnt_q + (AW+1)'(enq) - (AW+1)'(grant_ll);
        starve_d   = starve_q;
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        busy_d     = busy_q;

        if (empty || grant_ll) begin
            starve_d = '0;
        end else if (grant_wb && (starve_q != LIMIT)) begin
            starve_d = starve_q + 3'd1;
        end

        if (grant_wb) begin
            rf_we_d    = (bus.ws_waddr != '0);
            rf_waddr_d = bus.ws_waddr;
            rf_wdata_d = bus.ws_wdata;
        end else if (grant_ll) begin
            rf_we_d    = (head_addr != '0);
            rf_waddr_d = head_addr;
            rf_wdata_d = head_data;
        end

        // Clear first, then set, so a same-cycle reissue keeps the register busy.
        if (grant_ll) begin
            busy_d[head_addr] = 1'b0;
        end
        if (bus.ll_issue && (bus.ll_issue_dest != '0)) begin
            busy_d[bus.ll_issue_dest] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            starve_q   <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            busy_q     <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            starve_q   <= starve_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            busy_q     <= busy_d;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            mem_addr_q[wr_ptr_q] <= bus.ll_waddr;
            mem_data_q[wr_ptr_q] <= bus.ll_wdata;
        end
    end

    assign bus.ll_ready = !full;
    assign bus.ws_ready = !force_ll;
    assign bus.rf_we    = rf_we_q;
    assign bus.rf_waddr = rf_waddr_q;
    assign bus.rf_wdata = rf_wdata_q;
    assign bus.busy_vec = busy_q;
endmodule

// File: tb/tb_gpr_wport_arbiter.sv
// Bench for gpr_wport_arbiter: directed scenarios plus a randomized run against a queue-based model.
module tb_gpr_wport_arbiter;
    localparam int LIMIT = 4;
    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    gpr_wport_arbiter_if bus();

    gpr_wport_arbiter #(.STARVE_LIMIT(LIMIT), .LL_FIFO_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .resetn(resetn),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: LL buffer as a queue of {addr,data}
    logic [36:0] llq[$];
    int          m_starve;
    logic [31:0] m_busy;
    logic        m_we;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;

    always @(posedge clk) begin
        if (resetn && bus.ll_issue && bus.ll_issue_dest != 5'd0)
            assert (!bus.busy_vec[bus.ll_issue_dest])
            else $error("FAIL issue_to_busy dest=%0d busy_vec=%08h", bus.ll_issue_dest, bus.busy_vec);
    end

    task automatic model_reset();
        llq.delete();
        m_starve = 0;
        m_busy   = '0;
        m_we     = 1'b0;
        m_waddr  = '0;
        m_wdata  = '0;
    endtask

    task automatic model_clock();
        bit emp, full, frc, gw, gl;
        logic [36:0] head;
        emp  = (llq.size() == 0);
        full = (llq.size() >= DEPTH);
        frc  = !emp && (m_starve == LIMIT);
        gw   = !frc && bus.ws_valid;
        gl   = !gw && !emp;
        if (gw) begin
            m_we = (bus.ws_waddr != 0); m_waddr = bus.ws_waddr; m_wdata = bus.ws_wdata;
        end else if (gl) begin
            head = llq.pop_front();
            m_we = (head[36:32] != 0); m_waddr = head[36:32]; m_wdata = head[31:0];
            m_busy[head[36:32]] = 1'b0;
        end else begin
            m_we = 1'b0;
        end
        if (emp || gl) m_starve = 0;
        else if (m_starve < LIMIT) m_starve++;
        if (bus.ll_issue && bus.ll_issue_dest != 0) m_busy[bus.ll_issue_dest] = 1'b1;
        if (bus.ll_valid && !full) llq.push_back({bus.ll_waddr, bus.ll_wdata});
    endtask

    task automatic step();
        model_clock();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.ws_valid = 0; bus.ws_waddr = '0; bus.ws_wdata = '0;
        bus.ll_issue = 0; bus.ll_issue_dest = '0;
        bus.ll_valid = 0; bus.ll_waddr = '0; bus.ll_wdata = '0;
    endtask

    task automatic rand_ws();
        bus.ws_waddr = 5'(20 + $urandom_range(0, 11));
        bus.ws_wdata = $urandom;
    endtask

    task automatic drain();
        idle();
        for (int i = 0; i < 20 && llq.size() != 0; i++) step();
    endtask

    task automatic test_reset();
        idle();
        model_reset();
        resetn = 0;
        #12;
        checks++;
        if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== 38'd0) begin
            failures++; $display("FAIL reset_rf got=%0h exp=0", {bus.rf_we, bus.rf_waddr, bus.rf_wdata});
        end
        checks++;
        if (bus.busy_vec !== 32'd0) begin
            failures++; $display("FAIL reset_busy got=%08h exp=00000000", bus.busy_vec);
        end
        resetn = 1;
        #1;
        checks++;
        if ({bus.ws_ready, bus.ll_ready} !== 2'b11) begin
            failures++; $display("FAIL reset_ready got=%b exp=11", {bus.ws_ready, bus.ll_ready});
        end
        step();
    endtask

    task automatic test_wb_only();
        idle();
        bus.ws_valid = 1; bus.ws_waddr = 5'd5; bus.ws_wdata = 32'h1234_5678;
        checks++;
        if (bus.ws_ready !== 1'b1) begin
            failures++; $display("FAIL wb_ready got=%b exp=1", bus.ws_ready);
        end
        step();
        checks++;
        if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== {1'b1, 5'd5, 32'h1234_5678}) begin
            failures++; $display("FAIL wb_write got=%b/%0d/%08h exp=1/5/12345678", bus.rf_we, bus.rf_waddr, bus.rf_wdata);
        end
        bus.ws_waddr = 5'd0;
        checks++;
        if (bus.ws_ready !== 1'b1) begin
            failures++; $display("FAIL wb_r0_ready got=%b exp=1", bus.ws_ready);
        end
        step();
        checks++;
        if (bus.rf_we !== 1'b0) begin
            failures++; $display("FAIL wb_r0_we got=%b exp=0", bus.rf_we);
        end
        idle();
        step();
        checks++;
        if (bus.rf_we !== 1'b0) begin
            failures++; $display("FAIL idle_we got=%b exp=0", bus.rf_we);
        end
    endtask

    task automatic test_ll_path();
        drain();
        bus.ll_issue = 1; bus.ll_issue_dest = 5'd7;
        step();
        idle();
        checks++;
        if (bus.busy_vec[7] !== 1'b1) begin
            failures++; $display("FAIL ll_busy_set got=%b exp=1", bus.busy_vec[7]);
        end
        step();
        step();
        bus.ll_valid = 1; bus.ll_waddr = 5'd7; bus.ll_wdata = 32'hDEAD_BEEF;
        step();
        idle();
        checks++;
        if ({bus.rf_we, bus.busy_vec[7]} !== 2'b01) begin
            failures++; $display("FAIL ll_no_bypass got=%b exp=01", {bus.rf_we, bus.busy_vec[7]});
        end
        step();
        checks++;
        if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== {1'b1, 5'd7, 32'hDEAD_BEEF}) begin
            failures++; $display("FAIL ll_write got=%b/%0d/%08h exp=1/7/deadbeef", bus.rf_we, bus.rf_waddr, bus.rf_wdata);
        end
        checks++;
        if (bus.busy_vec[7] !== 1'b0) begin
            failures++; $display("FAIL ll_busy_clr got=%b exp=0", bus.busy_vec[7]);
        end
    endtask

    task automatic test_starvation();
        logic [31:0] lld;
        logic [4:0]  wa;
        logic [31:0] wd;
        drain();
        lld = $urandom;
        bus.ws_valid = 1; rand_ws();
        bus.ll_valid = 1; bus.ll_waddr = 5'd3; bus.ll_wdata = lld;
        step();
        bus.ll_valid = 0;
        for (int i = 0; i < 6; i++) begin
            rand_ws();
            wa = bus.ws_waddr; wd = bus.ws_wdata;
            checks++;
            if (bus.ws_ready !== (i != 4)) begin
                failures++; $display("FAIL starve_ready[%0d] got=%b exp=%b", i, bus.ws_ready, (i != 4));
            end
            step();
            checks++;
            if (i == 4 ? ({bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== {1'b1, 5'd3, lld})
                       : ({bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== {1'b1, wa, wd})) begin
                failures++; $display("FAIL starve_write[%0d] got=%0d/%08h exp=%0d/%08h", i, bus.rf_waddr, bus.rf_wdata,
                                     (i == 4) ? 5'd3 : wa, (i == 4) ? lld : wd);
            end
        end
        idle();
    endtask

    task automatic test_full_fifo();
        logic [36:0] exp_ll[3];
        logic [36:0] got[$];
        logic        prev_wsr;
        drain();
        for (int k = 0; k < 3; k++) exp_ll[k] = {5'(10 + k), 32'($urandom)};
        bus.ws_valid = 1;
        for (int k = 0; k < 2; k++) begin
            bus.ll_valid = 1; {bus.ll_waddr, bus.ll_wdata} = exp_ll[k]; rand_ws();
            checks++;
            if (bus.ll_ready !== 1'b1) begin
                failures++; $display("FAIL full_pre_ready[%0d] got=%b exp=1", k, bus.ll_ready);
            end
            step();
            if (bus.rf_we && bus.rf_waddr >= 10 && bus.rf_waddr <= 12) got.push_back({bus.rf_waddr, bus.rf_wdata});
        end
        {bus.ll_waddr, bus.ll_wdata} = exp_ll[2];
        checks++;
        if (bus.ll_ready !== 1'b0) begin
            failures++; $display("FAIL full_ready_low got=%b exp=0", bus.ll_ready);
        end
        prev_wsr = 1'b1;
        for (int n = 0; n < 20 && bus.ll_ready !== 1'b1; n++) begin
            prev_wsr = bus.ws_ready;
            rand_ws();
            step();
            if (bus.rf_we && bus.rf_waddr >= 10 && bus.rf_waddr <= 12) got.push_back({bus.rf_waddr, bus.rf_wdata});
        end
        checks++;
        if ({bus.ll_ready, prev_wsr} !== 2'b10) begin
            failures++; $display("FAIL full_ready_after_drain got=%b exp=10", {bus.ll_ready, prev_wsr});
        end
        rand_ws();
        step();
        bus.ll_valid = 0;
        for (int n = 0; n < 30 && got.size() < 3; n++) begin
            rand_ws();
            step();
            if (bus.rf_we && bus.rf_waddr >= 10 && bus.rf_waddr <= 12) got.push_back({bus.rf_waddr, bus.rf_wdata});
        end
        checks++;
        if (got.size() !== 3) begin
            failures++; $display("FAIL full_commit_count got=%0d exp=3", got.size());
        end
        for (int k = 0; k < 3 && k < got.size(); k++) begin
            checks++;
            if (got[k] !== exp_ll[k]) begin
                failures++; $display("FAIL full_order[%0d] got=%0h exp=%0h", k, got[k], exp_ll[k]);
            end
        end
        idle();
    endtask

    task automatic test_reset_midop();
        drain();
        bus.ll_issue = 1; bus.ll_issue_dest = 5'd7;
        step();
        bus.ll_issue_dest = 5'd8;
        step();
        bus.ll_issue = 0;
        bus.ws_valid = 1;
        for (int k = 0; k < 2; k++) begin
            rand_ws();
            bus.ll_valid = 1; bus.ll_waddr = 5'(7 + k); bus.ll_wdata = $urandom;
            step();
        end
        bus.ll_valid = 0;
        checks++;
        if ({bus.ll_ready, bus.busy_vec} !== {1'b0, 32'h0000_0180}) begin
            failures++; $display("FAIL midop_setup got=%b/%08h exp=0/00000180", bus.ll_ready, bus.busy_vec);
        end
        #2 resetn = 0;
        #1;
        checks++;
        if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.busy_vec} !== 70'd0) begin
            failures++; $display("FAIL midop_reset got=%b/%0d/%08h/%08h exp=0/0/0/0", bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.busy_vec);
        end
        model_reset();
        idle();
        #10 resetn = 1;
        #1;
        checks++;
        if ({bus.ws_ready, bus.ll_ready} !== 2'b11) begin
            failures++; $display("FAIL midop_release_ready got=%b exp=11", {bus.ws_ready, bus.ll_ready});
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (bus.rf_we !== 1'b0) begin
                failures++; $display("FAIL midop_stale_write[%0d] got=%b exp=0", i, bus.rf_we);
            end
        end
    endtask

    task automatic test_same_cycle();
        drain();
        bus.ll_valid = 1; bus.ll_waddr = 5'd9; bus.ll_wdata = $urandom;
        step();
        bus.ll_valid = 0;
        bus.ll_issue = 1; bus.ll_issue_dest = 5'd9;
        step();
        bus.ll_issue = 0;
        checks++;
        if ({bus.rf_we, bus.rf_waddr, bus.busy_vec[9]} !== {1'b1, 5'd9, 1'b1}) begin
            failures++; $display("FAIL same_cycle got=%b/%0d/%b exp=1/9/1", bus.rf_we, bus.rf_waddr, bus.busy_vec[9]);
        end
    endtask

    task automatic test_random();
        logic [4:0] d;
        for (int i = 0; i < 300; i++) begin
            bus.ws_valid = ($urandom_range(0, 3) != 0);
            bus.ws_waddr = 5'($urandom_range(0, 31));
            bus.ws_wdata = $urandom;
            bus.ll_valid = $urandom_range(0, 1);
            bus.ll_waddr = 5'($urandom_range(0, 31));
            bus.ll_wdata = $urandom;
            d = 5'($urandom_range(0, 31));
            if (m_busy[d]) d = 5'd0;
            bus.ll_issue = ($urandom_range(0, 3) == 0);
            bus.ll_issue_dest = d;
            checks++;
            if ({bus.ws_ready, bus.ll_ready} !== {!(llq.size() != 0 && m_starve == LIMIT), llq.size() < DEPTH}) begin
                failures++; $display("FAIL rand_ready[%0d] got=%b exp=%b", i, {bus.ws_ready, bus.ll_ready},
                                     {!(llq.size() != 0 && m_starve == LIMIT), llq.size() < DEPTH});
            end
            step();
            checks++;
            if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.busy_vec} !== {m_we, m_waddr, m_wdata, m_busy}) begin
                failures++; $display("FAIL rand_out[%0d] got=%b/%0d/%08h/%08h exp=%b/%0d/%08h/%08h", i,
                                     bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.busy_vec, m_we, m_waddr, m_wdata, m_busy);
            end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_wb_only();
        test_ll_path();
        test_starvation();
        test_full_fifo();
        test_reset_midop();
        test_same_cycle();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
